// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of i_pwm in prescaled ticks,
// exposes them on the peripheral register bus and as a duty-cycle output with a valid strobe.
module pwm_capture (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        re_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [31:0] rdata_o,
  output logic        error_o,
  input  logic        i_pwm,
  output logic [15:0] o_DC,
  output logic        o_valid_DC,
  output logic        intr_o
);

  localparam logic [7:0] ADDR_CTRL   = 8'd0;
  localparam logic [7:0] ADDR_DIV    = 8'd4;
  localparam logic [7:0] ADDR_PERIOD = 8'd8;
  localparam logic [7:0] ADDR_HIGH   = 8'd12;
  localparam logic [7:0] ADDR_STATUS = 8'd16;

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_e;

  // Registers
  logic        en_q, cont_q, ie_q, inv_q;
  logic [15:0] div_q, period_q, high_q;
  logic        done_q, ovf_q, valid_q;

  // Capture datapath
  state_e      state_q, state_d;
  logic [1:0]  sync_q;
  logic        edge_q;
  logic [15:0] cnt_q, cnt_d, pre_q, pre_d, high_lat_q, high_lat_d;
  logic        pwm_s, rise, fall, tick, sat;
  logic [16:0] cnt_sum;
  logic        capture, ovf_set, oneshot_clr;

  // Bus decode
  logic wr, wr_ctrl, wr_div, wr_status, abort, addr_mapped;

  logic unused_bits;
  assign unused_bits = ^{be_i, wdata_i[31:16]};

  assign wr        = we_i & ~re_i;
  assign wr_ctrl   = wr & (addr_i == ADDR_CTRL);
  assign wr_div    = wr & (addr_i == ADDR_DIV);
  assign wr_status = wr & (addr_i == ADDR_STATUS);
  // Disabling or CLR aborts the measurement on the same edge the write lands.
  assign abort     = wr_ctrl & (~wdata_i[0] | wdata_i[3]);

  assign addr_mapped = (addr_i == ADDR_CTRL) || (addr_i == ADDR_DIV) ||
                       (addr_i == ADDR_PERIOD) || (addr_i == ADDR_HIGH) ||
                       (addr_i == ADDR_STATUS);
  assign error_o = ((re_i | we_i) & ~addr_mapped) |
                   (we_i & ((addr_i == ADDR_PERIOD) | (addr_i == ADDR_HIGH)));

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      ADDR_CTRL:   rdata_o = {27'd0, inv_q, 1'b0, ie_q, cont_q, en_q};
      ADDR_DIV:    rdata_o = {16'd0, div_q};
      ADDR_PERIOD: rdata_o = {16'd0, period_q};
      ADDR_HIGH:   rdata_o = {16'd0, high_q};
      ADDR_STATUS: rdata_o = {30'd0, ovf_q, done_q};
      default:     rdata_o = '0;
    endcase
  end

  // Toggling INV flips pwm_s and may look like an edge; it is only meaningful while idle.
  assign pwm_s = sync_q[1] ^ inv_q;
  assign rise  = pwm_s & ~edge_q;
  assign fall  = ~pwm_s & edge_q;

  // >= rather than == so a DIVISOR lowered below the current phase still ticks next cycle.
  assign tick    = (pre_q >= div_q);
  assign cnt_sum = {1'b0, cnt_q} + {16'd0, tick};
  assign sat     = cnt_sum[16];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    high_lat_d  = high_lat_q;
    pre_d       = (rise || tick) ? 16'd0 : pre_q + 16'd1;
    capture     = 1'b0;
    ovf_set     = 1'b0;
    oneshot_clr = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rise) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        cnt_d = cnt_sum[15:0];
        if (sat) begin
          ovf_set = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (fall) begin
          high_lat_d = cnt_sum[15:0];
          state_d    = ST_LOW;
        end
      end
      ST_LOW: begin
        cnt_d = cnt_sum[15:0];
        if (sat) begin
          ovf_set = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (rise) begin
          capture = 1'b1;
          cnt_d   = '0;
          if (cont_q) begin
            state_d = ST_HIGH;
          end else begin
            state_d     = ST_IDLE;
            oneshot_clr = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort || !en_q) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      capture     = 1'b0;
      ovf_set     = 1'b0;
      oneshot_clr = 1'b0;
      if (abort) pre_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q     <= '0;
      edge_q     <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pre_q      <= '0;
      high_lat_q <= '0;
    end else begin
      sync_q     <= {sync_q[0], i_pwm};
      edge_q     <= pwm_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      high_lat_q <= high_lat_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      en_q     <= 1'b0;
      cont_q   <= 1'b0;
      ie_q     <= 1'b0;
      inv_q    <= 1'b0;
      div_q    <= '0;
      period_q <= '0;
      high_q   <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en_q   <= wdata_i[0];
        cont_q <= wdata_i[1];
        ie_q   <= wdata_i[2];
        inv_q  <= wdata_i[4];
      end
      if (oneshot_clr) en_q <= 1'b0;
      if (wr_div) div_q <= wdata_i[15:0];
      if (capture) begin
        period_q <= cnt_sum[15:0];
        high_q   <= high_lat_q;
      end
      valid_q <= capture;
      // Set events take priority over a simultaneous write-1-to-clear.
      done_q  <= capture | (done_q & ~(wr_status & wdata_i[0]));
      ovf_q   <= ovf_set | (ovf_q & ~(wr_status & wdata_i[1]));
    end
  end

  assign o_DC       = high_q;
  assign o_valid_DC = valid_q;
  assign intr_o     = ie_q & done_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: bus-access vector table, directed waveform scenarios,
// randomized waveforms checked against floor(interval/(DIVISOR+1)).
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re, we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        error;
  logic        i_pwm;
  logic [15:0] o_DC;
  logic        o_valid_DC;
  logic        intr;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [15:0] dc_q[$];
  int          vcyc_q[$];
  int          last_rise;
  int          exp_period, exp_high;

  pwm_capture dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .re_i       (re),
    .we_i       (we),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .be_i       (be),
    .rdata_o    (rdata),
    .error_o    (error),
    .i_pwm      (i_pwm),
    .o_DC       (o_DC),
    .o_valid_DC (o_valid_DC),
    .intr_o     (intr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && o_valid_DC) begin
      dc_q.push_back(o_DC);
      vcyc_q.push_back(cyc);
    end
  end

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        re;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } bus_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; re = 1'b0; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr = a; re = 1'b1;
    #1;
    check(name, rdata, exp);
    re = 1'b0;
  endtask

  // n full periods of h active + l inactive cycles, then a final rising edge held for 6 cycles.
  task automatic run_wave(input int h, input int l, input int n, input bit inv);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); i_pwm = ~inv; last_rise = cyc;
      repeat (h - 1) @(negedge clk);
      @(negedge clk); i_pwm = inv;
      repeat (l - 1) @(negedge clk);
    end
    @(negedge clk); i_pwm = ~inv; last_rise = cyc;
    repeat (6) @(negedge clk);
  endtask

  task automatic run_scenario(input int d, input int h, input int l, input int n,
                              input bit inv, input string tag);
    int base, exp_p, exp_h, lat;
    exp_p = (h + l) / (d + 1);
    exp_h = h / (d + 1);
    bus_write(8'd16, 32'h3);
    bus_write(8'd4, d);
    @(negedge clk); i_pwm = inv;
    repeat (5) @(negedge clk);
    bus_write(8'd0, inv ? 32'h13 : 32'h3);
    base = dc_q.size();
    run_wave(h, l, n, inv);
    bus_write(8'd0, 32'h0);
    @(negedge clk); i_pwm = 1'b0;
    repeat (5) @(negedge clk);
    check({tag, " valid pulses"}, dc_q.size() - base, n);
    for (int i = base; i < dc_q.size(); i++) check({tag, " o_DC"}, dc_q[i], exp_h);
    lat = (dc_q.size() > base) ? vcyc_q[vcyc_q.size() - 1] - last_rise : -1;
    check({tag, " capture latency"}, lat, 3);
    read_check({tag, " PERIOD"}, 8'd8, exp_p);
    read_check({tag, " HIGH"}, 8'd12, exp_h);
    read_check({tag, " STATUS"}, 8'd16, 32'h1);
    exp_period = exp_p;
    exp_high   = exp_h;
  endtask

  initial begin
    bus_vec_t vecs[$];
    int base;
    logic [7:0] reg_addrs[5];
    reg_addrs = '{8'd0, 8'd4, 8'd8, 8'd12, 8'd16};

    rst_n = 1'b0; re = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = 4'hF; i_pwm = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    check("reset o_DC", o_DC, 0);
    check("reset o_valid_DC", o_valid_DC, 0);
    check("reset intr_o", intr, 0);
    for (int i = 0; i < 5; i++) read_check("reset reg", reg_addrs[i], 0);

    // Bus access table: writes check error_o, reads check rdata_o and error_o.
    vecs.push_back('{1'b0, 1'b1, 8'd0,  32'h0000_FF1A, 32'h0,    1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'd0,  32'h0,         32'h12,   1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'd4,  32'hABCD_1234, 32'h0,    1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'd4,  32'h0,         32'h1234, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'd8,  32'h55,        32'h0,    1'b1});
    vecs.push_back('{1'b1, 1'b0, 8'd8,  32'h0,         32'h0,    1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'd12, 32'h66,        32'h0,    1'b1});
    vecs.push_back('{1'b1, 1'b0, 8'd12, 32'h0,         32'h0,    1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'd20, 32'h0,         32'h0,    1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'd24, 32'h1,         32'h0,    1'b1});
    vecs.push_back('{1'b1, 1'b0, 8'd3,  32'h0,         32'h0,    1'b1});
    vecs.push_back('{1'b1, 1'b1, 8'd4,  32'h77,        32'h1234, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'd4,  32'h0,         32'h1234, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'd0,  32'h0,         32'h0,    1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'd4,  32'h0,         32'h0,    1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'd0,  32'h0,         32'h0,    1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'd16, 32'h0,         32'h0,    1'b0});
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      re = vecs[i].re; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      check($sformatf("bus[%0d] error_o", i), error, vecs[i].exp_err);
      if (vecs[i].re) check($sformatf("bus[%0d] rdata_o", i), rdata, vecs[i].exp_rdata);
    end
    @(negedge clk); re = 1'b0; we = 1'b0;

    run_scenario(0, 25, 75, 3, 1'b0, "noprescale");
    run_scenario(3, 25, 75, 3, 1'b0, "prescale3");
    run_scenario(0, 25, 75, 2, 1'b1, "inverted");
    for (int t = 0; t < 8; t++) begin
      run_scenario($urandom_range(0, 3), $urandom_range(3, 30), $urandom_range(3, 30), 2,
                   1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
    end

    // One-shot with interrupt: a single capture, EN self-clears, W1C drops intr_o.
    bus_write(8'd16, 32'h3);
    bus_write(8'd4, 32'h0);
    bus_write(8'd0, 32'h5);
    base = dc_q.size();
    run_wave(10, 20, 3, 1'b0);
    check("oneshot valid pulses", dc_q.size() - base, 1);
    check("oneshot o_DC", o_DC, 10);
    read_check("oneshot CTRL", 8'd0, 32'h4);
    read_check("oneshot PERIOD", 8'd8, 30);
    check("oneshot intr set", intr, 1);
    bus_write(8'd16, 32'h1);
    check("oneshot intr cleared", intr, 0);
    exp_period = 30;
    bus_write(8'd0, 32'h0);
    @(negedge clk); i_pwm = 1'b0;
    repeat (5) @(negedge clk);

    // Abort during LOW: the following rise must not capture.
    bus_write(8'd0, 32'h3);
    base = dc_q.size();
    @(negedge clk); i_pwm = 1'b1;
    repeat (10) @(negedge clk);
    i_pwm = 1'b0;
    repeat (8) @(negedge clk);
    bus_write(8'd0, 32'h0);
    repeat (5) @(negedge clk);
    i_pwm = 1'b1;
    repeat (8) @(negedge clk);
    check("abort no strobe", dc_q.size() - base, 0);
    read_check("abort PERIOD kept", 8'd8, exp_period);
    i_pwm = 1'b0;
    repeat (5) @(negedge clk);

    // Reset mid-capture after one capture (period 20, high 10, divisor 2).
    bus_write(8'd4, 32'h2);
    bus_write(8'd0, 32'h7);
    @(negedge clk); i_pwm = 1'b1;
    repeat (10) @(negedge clk);
    i_pwm = 1'b0;
    repeat (10) @(negedge clk);
    i_pwm = 1'b1;
    repeat (8) @(negedge clk);
    check("pre-reset intr", intr, 1);
    check("pre-reset o_DC", o_DC, 3);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset o_DC", o_DC, 0);
    check("midreset o_valid_DC", o_valid_DC, 0);
    check("midreset intr", intr, 0);
    for (int i = 0; i < 5; i++) read_check("midreset reg", reg_addrs[i], 0);
    rst_n = 1'b1;
    exp_period = 0;
    i_pwm = 1'b0;
    repeat (5) @(negedge clk);

    // Overflow: one rise then stuck high; OVF lands 65539 edges after the transition.
    bus_write(8'd4, 32'h0);
    bus_write(8'd0, 32'h3);
    repeat (3) @(negedge clk);
    base = dc_q.size();
    @(negedge clk); i_pwm = 1'b1;
    repeat (65529) @(negedge clk);
    read_check("ovf not yet", 8'd16, 32'h0);
    repeat (14) @(negedge clk);
    read_check("ovf set", 8'd16, 32'h2);
    check("ovf no capture", dc_q.size() - base, 0);
    read_check("ovf PERIOD kept", 8'd8, exp_period);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
